// File: rtl/router_0_input_buffer_if.sv
// Input-port link bundle for router 0: upstream write side, downstream pop side, route requests.
// Latency: none (wires only).
// Backpressure: upstream observes full; downstream pops with rd_en.
interface router_0_input_buffer_if #(
    parameter int FLIT_W = 32
);
    logic [FLIT_W-1:0] data_in;
    logic              wr_en;
    logic              full;
    logic              rd_en;
    logic [FLIT_W-1:0] data_out;
    logic              empty;
    logic [2:0]        flit_type;
    logic [11:0]       length;
    logic              Lreq;
    logic              Ereq;
    logic              Sreq;
    logic              err;

    // Buffer side: accepts flits and pops, drives status and route requests
    modport slave (
        input  data_in, wr_en, rd_en,
        output full, data_out, empty, flit_type, length, Lreq, Ereq, Sreq, err
    );

    // Environment side: upstream link plus arbiter/crossbar
    modport master (
        output data_in, wr_en, rd_en,
        input  full, data_out, empty, flit_type, length, Lreq, Ereq, Sreq, err
    );
endinterface

// File: rtl/router_0_input_buffer.sv
// Router 0 input buffer: DEPTH-flit FIFO with XY route decode of the head header flit.
// Latency: write visible at head next cycle; route request one cycle after header reaches head.
// Backpressure: writes dropped while full; pops only on rd_en; stray non-header flits self-popped in IDLE.
module router_0_input_buffer #(
    parameter int FLIT_W = 32,
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    router_0_input_buffer_if.slave bus
);

    localparam logic [2:0] FT_HEADER = 3'd1;
    localparam logic [2:0] FT_TAIL   = 3'd3;

    localparam int TYPE_HI = FLIT_W - 1;
    localparam int LEN_HI  = FLIT_W - 4;
    localparam int DX_BIT  = FLIT_W - 16;
    localparam int DY_BIT  = FLIT_W - 17;

    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ROUTED = 1'b1
    } state_e;

    logic [FLIT_W-1:0] mem_q [DEPTH];
    logic [FLIT_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    cnt_q, cnt_d;
    state_e            state_q, state_d;
    logic [11:0]       length_q, length_d;
    logic              lreq_q, lreq_d;
    logic              ereq_q, ereq_d;
    logic              sreq_q, sreq_d;
    logic              err_q, err_d;

    logic              empty;
    logic              full;
    logic              do_wr;
    logic              do_pop;
    logic [FLIT_W-1:0] head;
    logic [2:0]        head_type;

    // FIFO status and head-flit decode; outputs masked to zero while empty
    always_comb begin
        empty     = (cnt_q == '0);
        full      = (cnt_q == CNT_FULL);
        head      = mem_q[rd_ptr_q];
        head_type = head[TYPE_HI -: 3];

        bus.empty     = empty;
        bus.full      = full;
        bus.data_out  = empty ? '0 : head;
        bus.flit_type = empty ? 3'b000 : head_type;
        bus.length    = length_q;
        bus.Lreq      = lreq_q;
        bus.Ereq      = ereq_q;
        bus.Sreq      = sreq_q;
        bus.err       = err_q;
    end

    // Packet FSM: route on header in IDLE, discard strays, hold request until the tail is popped
    always_comb begin
        state_d  = state_q;
        length_d = length_q;
        lreq_d   = lreq_q;
        ereq_d   = ereq_q;
        sreq_d   = sreq_q;
        err_d    = 1'b0;
        do_pop   = bus.rd_en && !empty;

        case (state_q)
            S_IDLE: begin
                lreq_d = 1'b0;
                ereq_d = 1'b0;
                sreq_d = 1'b0;
                if (!empty) begin
                    if (head_type == FT_HEADER) begin
                        state_d  = S_ROUTED;
                        length_d = head[LEN_HI -: 12];
                        // X first: any eastward destination leaves east, then south, else local
                        if (head[DX_BIT]) begin
                            ereq_d = 1'b1;
                        end else if (head[DY_BIT]) begin
                            sreq_d = 1'b1;
                        end else begin
                            lreq_d = 1'b1;
                        end
                    end else begin
                        do_pop = 1'b1;
                        err_d  = 1'b1;
                    end
                end
            end
            S_ROUTED: begin
                // Requests stay up while the FIFO runs dry mid-packet so the grant is not lost
                if (do_pop && head_type == FT_TAIL) begin
                    state_d = S_IDLE;
                    lreq_d  = 1'b0;
                    ereq_d  = 1'b0;
                    sreq_d  = 1'b0;
                end
            end
        endcase
    end

    // FIFO pointer/count/storage next-state; full is judged on the pre-edge count
    always_comb begin
        do_wr = bus.wr_en && !full;
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (do_wr) begin
            mem_d[wr_ptr_q] = bus.data_in;
        end
        wr_ptr_d = wr_ptr_q + PTR_W'(do_wr);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        cnt_d    = cnt_q + (PTR_W+1)'(do_wr) - (PTR_W+1)'(do_pop);
    end

    // State registers with synchronous reset; reset drops any packet in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            state_q  <= S_IDLE;
            length_q <= '0;
            lreq_q   <= 1'b0;
            ereq_q   <= 1'b0;
            sreq_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            length_q <= length_d;
            lreq_q   <= lreq_d;
            ereq_q   <= ereq_d;
            sreq_q   <= sreq_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_router_0_input_buffer.sv
// Bench for router 0 input buffer: queue-based packet model feeding two scoreboards.
// Stimulus pushes per-cycle expected status and expected delivered flits; a negedge monitor compares.
// Directed scenarios first, then randomized packet traffic with random pops and occasional resets.
module tb_router_0_input_buffer;

    localparam logic [2:0] T_HDR  = 3'd1;
    localparam logic [2:0] T_PAY  = 3'd2;
    localparam logic [2:0] T_TAIL = 3'd3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    router_0_input_buffer_if #(.FLIT_W(32)) bus ();

    router_0_input_buffer #(.FLIT_W(32), .DEPTH(4), .PTR_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        empty;
        logic        full;
        logic [31:0] dout;
        logic [2:0]  ft;
        logic [11:0] len;
        logic [2:0]  req;
        logic        err;
    } stat_t;

    typedef struct packed {
        logic [31:0] dat;
        logic [2:0]  req;
    } dlv_t;

    stat_t stat_q[$];
    dlv_t  dlv_q[$];

    // Reference model: flit queue plus packet-level routing state
    logic [31:0] m_q[$];
    bit          m_routed = 0;
    logic [2:0]  m_req    = 3'b000;   // {L,E,S}
    logic [11:0] m_len    = 12'd0;
    bit          m_err    = 0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [2:0] t, input int len, input bit dx, input bit dy);
        logic [14:0] lo;
        lo = 15'($urandom);
        return {t, 12'(len), dx, dy, lo};
    endfunction

    // XY route for router (0,0) as {L,E,S}
    function automatic logic [2:0] route_of(input logic [31:0] f);
        if (f[16])      return 3'b010;
        else if (f[15]) return 3'b001;
        else            return 3'b100;
    endfunction

    // One clock cycle: drive inputs, record expectations, advance the model across the edge
    task automatic cyc(input bit w, input logic [31:0] d, input bit r_req, input bit rs);
        stat_t       s;
        dlv_t        dv;
        bit          emp, fullp, r, popped_err;
        logic [31:0] h;
        r     = r_req && m_routed && !rs;
        emp   = (m_q.size() == 0);
        fullp = (m_q.size() == 4);
        h     = emp ? 32'd0 : m_q[0];
        rst        = rs;
        bus.wr_en  = w;
        bus.data_in = d;
        bus.rd_en  = r;
        s.empty = emp;
        s.full  = fullp;
        s.dout  = h;
        s.ft    = h[31:29];
        s.len   = m_len;
        s.req   = m_req;
        s.err   = m_err;
        stat_q.push_back(s);
        if (r && !emp) begin
            dv.dat = h;
            dv.req = m_req;
            dlv_q.push_back(dv);
        end
        @(posedge clk);
        if (rs) begin
            m_q.delete();
            m_routed = 0;
            m_req    = 3'b000;
            m_len    = 12'd0;
            m_err    = 0;
        end else begin
            popped_err = 0;
            if (!emp) begin
                if (!m_routed) begin
                    if (h[31:29] != T_HDR) begin
                        void'(m_q.pop_front());
                        popped_err = 1;
                    end else begin
                        m_routed = 1;
                        m_len    = h[28:17];
                        m_req    = route_of(h);
                    end
                end else if (r) begin
                    void'(m_q.pop_front());
                    if (h[31:29] == T_TAIL) begin
                        m_routed = 0;
                        m_req    = 3'b000;
                    end
                end
            end
            if (w && !fullp) m_q.push_back(d);
            m_err = popped_err;
        end
        #1;
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) cyc(0, 32'd0, r, 0);
    endtask

    // Monitor: compare status every cycle and each flit handed downstream
    always @(negedge clk) begin
        stat_t s;
        dlv_t  dv;
        if (stat_q.size() > 0) begin
            s = stat_q.pop_front();
            chk("empty",     32'(bus.empty),     32'(s.empty));
            chk("full",      32'(bus.full),      32'(s.full));
            chk("data_out",  bus.data_out,       s.dout);
            chk("flit_type", 32'(bus.flit_type), 32'(s.ft));
            chk("length",    32'(bus.length),    32'(s.len));
            chk("reqs",      32'({bus.Lreq, bus.Ereq, bus.Sreq}), 32'(s.req));
            chk("err",       32'(bus.err),       32'(s.err));
        end
        if (bus.rd_en && !bus.empty) begin
            if (dlv_q.size() == 0) begin
                checks++;
                errors++;
                if (errors <= 40) $display("FAIL dlv_unexpected: got pop of %h expected no pop", bus.data_out);
            end else begin
                dv = dlv_q.pop_front();
                chk("dlv_data", bus.data_out, dv.dat);
                chk("dlv_req",  32'({bus.Lreq, bus.Ereq, bus.Sreq}), 32'(dv.req));
            end
        end
    end

    initial begin
        logic [31:0] pend;
        int          left;
        int          plen;
        int          t;
        bit          have, w, r, rs, acc;

        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.data_in = 32'd0;
        @(posedge clk);
        #1;

        // Reset then idle
        cyc(0, 32'd0, 0, 1);
        idle(2, 0);

        // Single 3-flit packet to the east, popped every cycle
        cyc(1, mk(T_HDR, 3, 1, 0), 1, 0);
        cyc(1, mk(T_PAY, 0, 0, 0), 1, 0);
        cyc(1, mk(T_TAIL, 0, 0, 0), 1, 0);
        idle(5, 1);

        // Routing coverage: (0,1) south, (0,0) local, (1,1) east
        cyc(1, mk(T_HDR, 2, 0, 1), 1, 0);
        cyc(1, mk(T_TAIL, 0, 0, 0), 1, 0);
        idle(3, 1);
        cyc(1, mk(T_HDR, 2, 0, 0), 1, 0);
        cyc(1, mk(T_TAIL, 0, 0, 0), 1, 0);
        idle(3, 1);
        cyc(1, mk(T_HDR, 2, 1, 1), 1, 0);
        cyc(1, mk(T_TAIL, 0, 0, 0), 1, 0);
        idle(3, 1);

        // Fill past capacity, then pop two and write two across the pointer wrap
        cyc(1, mk(T_HDR, 4, 0, 0), 0, 0);
        cyc(1, mk(T_PAY, 0, 0, 0), 0, 0);
        cyc(1, mk(T_PAY, 0, 0, 0), 0, 0);
        cyc(1, mk(T_TAIL, 0, 0, 0), 0, 0);
        cyc(1, mk(T_PAY, 0, 1, 1), 0, 0);
        idle(1, 0);
        cyc(1, mk(T_PAY, 0, 1, 0), 1, 0);
        idle(1, 1);
        cyc(1, mk(T_HDR, 2, 0, 1), 0, 0);
        cyc(1, mk(T_TAIL, 0, 0, 0), 0, 0);
        idle(8, 1);

        // Back-to-back packets: local then south, queued before any pop
        cyc(1, mk(T_HDR, 2, 0, 0), 0, 0);
        cyc(1, mk(T_TAIL, 0, 0, 0), 0, 0);
        cyc(1, mk(T_HDR, 2, 0, 1), 0, 0);
        cyc(1, mk(T_TAIL, 0, 0, 0), 0, 0);
        idle(8, 1);

        // Stray payload at head in IDLE
        cyc(1, mk(T_PAY, 0, 1, 0), 0, 0);
        idle(3, 0);

        // Reset mid-packet while routed east
        cyc(1, mk(T_HDR, 3, 1, 0), 0, 0);
        cyc(1, mk(T_PAY, 0, 0, 0), 0, 0);
        idle(1, 0);
        cyc(0, 32'd0, 0, 1);
        idle(2, 0);

        // Randomized packet traffic
        left = 0;
        have = 0;
        pend = 32'd0;
        for (int i = 0; i < 3000; i++) begin
            if (!have) begin
                if (left == 0) begin
                    if ($urandom_range(7) == 0) begin
                        t = $urandom_range(7);
                        if (t == 1) t = 2;
                        pend = mk(3'(t), 0, 1'($urandom_range(1)), 1'($urandom_range(1)));
                    end else begin
                        plen = $urandom_range(2, 5);
                        pend = mk(T_HDR, plen, 1'($urandom_range(1)), 1'($urandom_range(1)));
                        left = plen - 1;
                    end
                end else begin
                    pend = mk((left == 1) ? T_TAIL : T_PAY, 0, 1'($urandom_range(1)), 1'($urandom_range(1)));
                    left--;
                end
                have = 1;
            end
            rs  = ($urandom_range(299) == 0);
            w   = !rs && ($urandom_range(9) < 6);
            r   = ($urandom_range(9) < 7);
            acc = w && (m_q.size() < 4);
            cyc(w, pend, r, rs);
            if (acc) have = 0;
            if (rs) left = 0;
        end

        idle(2, 0);
        chk("dlv_queue_drained",  32'(dlv_q.size()),  32'd0);
        chk("stat_queue_drained", 32'(stat_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/router_0_input_buffer.md
# router_0_input_buffer

Input port stage for router 0 (node (0,0)) of the 2x2 2D mesh. It buffers incoming flits in a small FIFO and decodes the header flit at the FIFO head. It computes the XY route and holds one-hot output-port requests (Lreq/Ereq/Sreq) for the whole packet. It feeds the round-robin arbiter (flit type, packet length, requests) and the crossbar (flit data).

## Interface
- FLIT_W, 32, flit width; fields: [31:29] flit type, [28:17] packet length (header only), [16] dest X, [15] dest Y
- DEPTH, 4, FIFO depth in flits (power of 2)
- PTR_W, 2, log2(DEPTH)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- data_in  in  FLIT_W  flit from upstream link
- wr_en  in  1  write strobe; ignored when full=1
- full  out  1  FIFO holds DEPTH flits
- rd_en  in  1  pop head flit (grant from crossbar/output side); ignored when empty=1
- data_out  out  FLIT_W  head flit, combinational from storage; 0 when empty
- empty  out  1  FIFO holds 0 flits
- flit_type  out  3  head flit [31:29] when not empty, else 3'b000
- length  out  12  registered length of current packet
- Lreq, Ereq, Sreq  out  1 each  registered one-hot route request, held header-to-tail
- err  out  1  one-cycle pulse: non-header flit discarded in IDLE

## Operation
- FIFO: write pointer, read pointer, count register (PTR_W+1 bits); pointers wrap modulo DEPTH.
- Write and read in the same cycle when neither full nor empty: count unchanged.
- Write while full is dropped, with no side effects. Read while empty is ignored.
- Full and simultaneous read: the write is still rejected (full is evaluated before the edge).
- FSM, 2 states:
  - IDLE: reqs 0.
    - Head type == `HEADER` with empty=0: latch length=[28:17] and compute route, then go to ROUTED.
    - Head type != `HEADER` with empty=0: auto-pop the flit (read pointer advances), pulse err; stay IDLE.
  - ROUTED: exactly one req high. If rd_en=1, empty=0 and head type == `TAIL`, go to IDLE and clear reqs. Otherwise stay.
- Route (XY, router at (0,0)): dest X=1 gives Ereq; else dest Y=1 gives Sreq; else Lreq.
- Reqs stay high in ROUTED even while the FIFO is temporarily empty mid-packet. This prevents the arbiter from releasing the grant.
- In ROUTED, popping a flit does not re-route. A `HEADER` flit popped while in ROUTED is forwarded unchanged, with no err.
- Reset: FIFO cleared, pointers/count 0, state IDLE; full=0, empty=1, data_out=0, flit_type=0, length=0, all reqs=0, err=0. Reset mid-packet discards the packet.

## Timing
- Write at edge N: empty=0, data_out and flit_type valid after edge N (cycle N+1).
- Header at head in cycle N (IDLE): req and length valid from cycle N+1.
- Tail popped at edge M: reqs low in cycle M+1.
- A following header already at head is routed at edge M+1, so its req is high from M+2. This is a one-cycle inter-packet bubble.
- Non-header discard in IDLE: one flit per cycle; err high the cycle after the discarding edge.
- full/empty/count update on the same edge as the write/read. No combinational path from rd_en to full.

## Test plan
- Reset then idle: after rst, empty=1, full=0, Lreq=Ereq=Sreq=0, length=0, flit_type=0.
- Single 3-flit packet with header dest X=1,Y=0, length=3: Ereq=1 one cycle after the header reaches head, length=3. Pop one flit per cycle. Ereq drops the cycle after the tail pop.
- Routing coverage: dest (0,1) gives Sreq; dest (0,0) gives Lreq; dest (1,1) gives Ereq.
- Full/wrap:
  - Write 5 flits with no reads: 5th dropped, full=1 after the 4th.
  - Pop 2, write 2: data_out order matches write order across pointer wrap.
- Back-to-back packets: two 2-flit packets (L then S) queued. Lreq drops after the first tail. Sreq rises exactly one cycle later.
- Error/reset:
  - `PAYLOAD` flit at head in IDLE: auto-popped, err pulses 1 cycle, reqs stay 0.
  - rst asserted mid-packet with Ereq=1: next cycle Ereq=0, empty=1.
